pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Parametrised pipeline stage register, successor to the fixed-field stage latches.
//  Carries an opaque control bundle and data bundle between two pipeline stages.
//  Uses a valid/ready handshake with a 2-entry skid buffer, so backpressure never
//  drops or duplicates an instruction.
//  A synchronous flush squashes in-flight entries and turns them into bubbles.
//  Default sizing is for the ID->EX boundary.
// PARAMETERS
//  CTRL_W      9    control bundle width; a bubble drives all-zero (ALUOp,ALUSrc,BrEq,BrGt,MemRd,MemWr,RegWr,MemtoReg)
//  DATA_W      275  data bundle width (instr 4 + rd/rs1/rs2 15 + rd1/rd2/imm/pc 4x64)
//  CNT_W       32   perf counter width (used only with STAGE_PERF_CNT_EN)
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-high reset
//  flush        in   1       synchronous squash of all held entries
//  in_valid     in   1       upstream entry valid
//  in_ready     out  1       stage can accept; registered
//  in_ctrl      in   CTRL_W  upstream control bundle
//  in_data      in   DATA_W  upstream data bundle
//  out_valid    out  1       main entry valid
//  out_ready    in   1       downstream accepts (0 = hazard stall)
//  out_ctrl     out  CTRL_W  main control; forced to 0 when out_valid=0
//  out_data     out  DATA_W  main data; not gated
//  stall_cnt    out  CNT_W   cycles with out_valid & !out_ready  [macro only]
//  bubble_cnt   out  CNT_W   cycles with !out_valid              [macro only]
//  flush_cnt    out  CNT_W   flush assertions                    [macro only]
// BEHAVIOUR
//  Reset values (async):
//   - main and skid regs all-zero; out_valid=0; out_ctrl=0; out_data=0
//   - in_ready=1; state EMPTY; counters 0
//  Definitions:
//   - transfer-in  = in_valid & in_ready
//   - transfer-out = out_valid & out_ready
//  Latency 1 cycle in->out; throughput 1 entry/cycle while out_ready=1.
//  FSM (main valid, skid valid):
//   - EMPTY: transfer-in -> load main -> BUSY.
//   - BUSY, transfer-in & out_ready: main<=in, stay.
//   - BUSY, transfer-in & !out_ready: skid<=in -> FULL; in_ready=0 next cycle.
//   - BUSY, !in_valid & out_ready: -> EMPTY.
//   - BUSY, !in_valid & !out_ready: hold.
//   - FULL: in_ready=0, so no transfer-in possible.
//   - FULL, out_ready: main<=skid -> BUSY; in_ready=1 next cycle.
//   - FULL, !out_ready: hold both entries.
//  in_ready = !skid_valid, registered; never combinationally depends on out_ready.
//  Entries leave in strict FIFO order; main and skid contents never both hold the same entry.
//  flush has top priority over every transition:
//   - next cycle EMPTY, out_valid=0, out_ctrl=0, in_ready=1
//   - an entry offered in the flush cycle is dropped
//   - data regs keep their contents (don't-care)
//  reset asserted mid-operation: immediate return to reset values; in-flight entries lost.
//  in_valid=0 while in_ready=1: nothing loaded; in_ctrl/in_data ignored.
// CONFIGURATION
//  STAGE_PERF_CNT_EN defined:
//   - stall_cnt, bubble_cnt and flush_cnt ports exist.
//   - Counters increment once per qualifying clk and saturate at all-ones (no wrap).
//   - flush clears none of them; only reset clears them.
//  STAGE_PERF_CNT_EN undefined:
//   - Counter ports and logic are absent.
//   - Handshake behaviour is identical.
// TESTING
//  1 Reset: reset=1 mid-stream -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1 immediately.
//  2 Streaming: send A,B,C on consecutive cycles with out_ready=1 -> A,B,C on out one cycle later each; in_ready stays 1.
//  3 Backpressure: with A in main, out_ready=0, send B.
//    -> B to skid; in_ready=0 next cycle; out holds A.
//    -> Raise out_ready: A accepted, then B; no loss or duplicate.
//  4 Flush in FULL with in_valid=1 -> next cycle out_valid=0, out_ctrl=9'h000, in_ready=1; offered entry never appears.
//  5 Bubble gating: in_ctrl=9'h1FF, in_valid=0 -> out_ctrl=0 throughout.
//  6 STAGE_PERF_CNT_EN: 3 stall cycles, 2 idle cycles, 1 flush.
//    -> stall_cnt=3, bubble_cnt>=2, flush_cnt=1.
//    -> Preload CNT_W=4 and stall 20 cycles -> stall_cnt=4'hF.

Source files
------------

// File: rtl/pipe_stage_buf.sv
//------------------------------------------------------------------------------
// Module  : pipe_stage_buf
// Purpose : Parametrised pipeline stage register carrying an opaque control
//           bundle and data bundle between two pipeline stages. Uses a
//           valid/ready handshake backed by a 2-entry skid buffer (main + skid)
//           so that backpressure never drops or duplicates an entry. A
//           synchronous flush squashes every held entry into a bubble.
//           Default sizing targets the ID->EX boundary.
// Optional: STAGE_PERF_CNT_EN adds saturating stall/bubble/flush counters.
// Ports   :
//   clk        in   1       clock, rising edge
//   reset      in   1       asynchronous, active-high reset
//   flush      in   1       synchronous squash of all held entries
//   in_valid   in   1       upstream entry valid
//   in_ready   out  1       stage can accept (registered)
//   in_ctrl    in   CTRL_W  upstream control bundle
//   in_data    in   DATA_W  upstream data bundle
//   out_valid  out  1       main entry valid
//   out_ready  in   1       downstream accepts (0 = hazard stall)
//   out_ctrl   out  CTRL_W  main control, zero while out_valid=0
//   out_data   out  DATA_W  main data, not gated
//   stall_cnt  out  CNT_W   cycles with out_valid & !out_ready (optional)
//   bubble_cnt out  CNT_W   cycles with !out_valid             (optional)
//   flush_cnt  out  CNT_W   flush assertions                   (optional)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_stage_buf #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 275,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef STAGE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    // Elaboration-time sanity check of the counter width.
    if (CNT_W < 1) begin : g_cnt_w_invalid
        $error("pipe_stage_buf: CNT_W must be at least 1");
    end

    // State encodes (main valid, skid valid): EMPTY=(0,0) BUSY=(1,0) FULL=(1,1)
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_in_ready;

    logic              w_transfer_in;
    logic              w_load_main_in;
    logic              w_load_main_skid;
    logic              w_load_skid;

    assign w_transfer_in = in_valid & r_in_ready;

    //--------------------------------------------------------------------------
    // Next-state and register-load decode
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;

        case (r_state)
            S_EMPTY: begin
                if (w_transfer_in) begin
                    w_load_main_in = 1'b1;
                    w_state_nxt    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_transfer_in && out_ready) begin
                    w_load_main_in = 1'b1;
                end else if (w_transfer_in) begin
                    // Downstream stalled: park the new entry behind main.
                    w_load_skid = 1'b1;
                    w_state_nxt = S_FULL;
                end else if (out_ready) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                // in_ready is low here, so only the skid can advance.
                if (out_ready) begin
                    w_load_main_skid = 1'b1;
                    w_state_nxt      = S_BUSY;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase

        // Flush wins over every transition; offered entry is dropped.
        if (flush) begin
            w_state_nxt      = S_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    //--------------------------------------------------------------------------
    // State register and registered in_ready
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            // Ready depends only on whether the skid will be occupied, never
            // combinationally on out_ready.
            r_in_ready <= (w_state_nxt != S_FULL);
        end
    end

    //--------------------------------------------------------------------------
    // Main and skid payload registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end else if (w_load_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != S_EMPTY);
    // A bubble must present all-zero control so downstream does no work.
    assign out_ctrl  = out_valid ? r_main_ctrl : '0;
    assign out_data  = r_main_data;

`ifdef STAGE_PERF_CNT_EN
    //--------------------------------------------------------------------------
    // Saturating performance counters; cleared only by reset
    //--------------------------------------------------------------------------
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
            end
            if (!out_valid && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + C_CNT_ONE;
            end
            if (flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + C_CNT_ONE;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
//------------------------------------------------------------------------------
// Module  : tb_pipe_stage_buf
// Purpose : Self-checking bench for pipe_stage_buf: directed vector table for
//           streaming, backpressure, flush and bubble gating, plus hand-written
//           sequences for async reset, FIFO ordering and optional counters.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_buf;

    localparam int CTRL_W = 9;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
`ifdef STAGE_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    pipe_stage_buf #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_data   (out_data)
`ifdef STAGE_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              iv;
        logic              ordy;
        logic              fl;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        logic              e_ov;
        logic              e_ir;
        logic [CTRL_W-1:0] e_ctrl;
        logic [DATA_W-1:0] e_data;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl,
                         input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_ctrl   = c;
        in_data   = d;
    endtask

    // FIFO-order model state
    logic [CTRL_W+DATA_W-1:0] exp_q [$];
    logic [CTRL_W+DATA_W-1:0] popped;
    int sent;
    int rcvd;

    initial begin
        // Expected values are the outputs seen just after the clock edge that
        // consumed the row's inputs.
        //           iv ordy fl ctrl    data      ov ir e_ctrl  e_data
        // streaming A,B,C then bubbles with all-ones control offered
        vecs[0]  = '{1, 1, 0, 9'h011, 16'hA001, 1, 1, 9'h011, 16'hA001};
        vecs[1]  = '{1, 1, 0, 9'h022, 16'hB002, 1, 1, 9'h022, 16'hB002};
        vecs[2]  = '{1, 1, 0, 9'h033, 16'hC003, 1, 1, 9'h033, 16'hC003};
        vecs[3]  = '{0, 1, 0, 9'h1FF, 16'hFFFF, 0, 1, 9'h000, 16'hC003};
        vecs[4]  = '{0, 1, 0, 9'h1FF, 16'hFFFF, 0, 1, 9'h000, 16'hC003};
        // backpressure: D main, E to skid, F refused until skid drains
        vecs[5]  = '{1, 0, 0, 9'h044, 16'hD004, 1, 1, 9'h044, 16'hD004};
        vecs[6]  = '{1, 0, 0, 9'h055, 16'hE005, 1, 0, 9'h044, 16'hD004};
        vecs[7]  = '{1, 0, 0, 9'h066, 16'hF006, 1, 0, 9'h044, 16'hD004};
        vecs[8]  = '{1, 1, 0, 9'h066, 16'hF006, 1, 1, 9'h055, 16'hE005};
        vecs[9]  = '{1, 1, 0, 9'h066, 16'hF006, 1, 1, 9'h066, 16'hF006};
        vecs[10] = '{0, 0, 0, 9'h000, 16'h0000, 1, 1, 9'h066, 16'hF006};
        vecs[11] = '{0, 1, 0, 9'h000, 16'h0000, 0, 1, 9'h000, 16'hF006};
        // flush in FULL with an entry offered
        vecs[12] = '{1, 0, 0, 9'h077, 16'h1007, 1, 1, 9'h077, 16'h1007};
        vecs[13] = '{1, 0, 0, 9'h088, 16'h2008, 1, 0, 9'h077, 16'h1007};
        vecs[14] = '{1, 0, 1, 9'h099, 16'h3009, 0, 1, 9'h000, 16'h1007};
        vecs[15] = '{0, 1, 0, 9'h000, 16'h0000, 0, 1, 9'h000, 16'h1007};
        // flush in BUSY and in EMPTY, each with an entry offered
        vecs[16] = '{1, 1, 0, 9'h0AA, 16'h400A, 1, 1, 9'h0AA, 16'h400A};
        vecs[17] = '{1, 1, 1, 9'h0BB, 16'h500B, 0, 1, 9'h000, 16'h400A};
        vecs[18] = '{1, 1, 1, 9'h0CC, 16'h600C, 0, 1, 9'h000, 16'h400A};
        vecs[19] = '{0, 1, 0, 9'h000, 16'h0000, 0, 1, 9'h000, 16'h400A};
        // full-ones control passes when valid, gated when bubble
        vecs[20] = '{1, 1, 0, 9'h1FF, 16'h7777, 1, 1, 9'h1FF, 16'h7777};
        vecs[21] = '{0, 1, 0, 9'h1FF, 16'h8888, 0, 1, 9'h000, 16'h7777};

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        tick();
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready",  {31'd0, in_ready},  32'd1);
        check("reset_out_ctrl",  {23'd0, out_ctrl},  32'd0);
        check("reset_out_data",  {16'd0, out_data},  32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].ctrl, vecs[i].data);
            tick();
            check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
            check($sformatf("vec%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].e_ir});
            check($sformatf("vec%0d_out_ctrl", i),  {23'd0, out_ctrl},  {23'd0, vecs[i].e_ctrl});
            check($sformatf("vec%0d_out_data", i),  {16'd0, out_data},  {16'd0, vecs[i].e_data});
        end

        // Asynchronous reset while FULL: outputs must clear before any edge.
        drive(1'b1, 1'b0, 1'b0, 9'h0D1, 16'h9001);
        tick();
        drive(1'b1, 1'b0, 1'b0, 9'h0D2, 16'h9002);
        tick();
        check("pre_reset_full_in_ready", {31'd0, in_ready}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_reset_out_ctrl",  {23'd0, out_ctrl},  32'd0);
        check("async_reset_out_data",  {16'd0, out_data},  32'd0);
        check("async_reset_in_ready",  {31'd0, in_ready},  32'd1);
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        tick();
        check("post_reset_no_stale", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 9'h0E1, 16'h9E01);
        tick();
        check("post_reset_accept", {16'd0, out_data}, 32'h9E01);
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        tick();

        // FIFO ordering under irregular backpressure: every accepted entry
        // must leave exactly once, in order.
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 80 && rcvd < 10; cyc++) begin
            drive((sent < 10) && (cyc % 4 != 3), (cyc % 3 != 1), 1'b0,
                  CTRL_W'(sent + 1), DATA_W'(16'h5100 + sent));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("fifo_unexpected_out", {16'd0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    popped = exp_q.pop_front();
                    check($sformatf("fifo_out%0d", rcvd), {7'd0, out_ctrl, out_data}, {7'd0, popped});
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({in_ctrl, in_data});
                sent++;
            end
            tick();
        end
        check("fifo_all_received", rcvd, 32'd10);
        check("fifo_queue_empty", exp_q.size(), 32'd0);
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        tick();

`ifdef STAGE_PERF_CNT_EN
        reset = 1'b1;
        #1;
        check("cnt_reset_stall", {28'd0, stall_cnt}, 32'd0);
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 9'h011, 16'h1111);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        tick();
        tick();
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        tick();
        tick();
        tick();
        drive(1'b0, 1'b1, 1'b1, '0, '0);
        tick();
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        check("cnt_stall_3", {28'd0, stall_cnt}, 32'd3);
        check("cnt_flush_1", {28'd0, flush_cnt}, 32'd1);
        check("cnt_bubble_ge2", {31'd0, (bubble_cnt >= 4'd2)}, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 9'h022, 16'h2222);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 20; k++) tick();
        check("cnt_stall_saturate", {28'd0, stall_cnt}, 32'hF);
        check("cnt_flush_kept", {28'd0, flush_cnt}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
